// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the MIPS datapath.
// 32 cycles per MULT/MULTU/DIV/DIVU; HI/LO also written by MTHI/MTLO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, acc_nxt;
  logic [W-1:0]   b_q;
  logic           div_q, sa_q, neg_q, dz_q;

  logic           sgn, sa, sb;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     sum;
  logic [W+1:0]   trial;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;
  logic           last;

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign last = (cnt == CW'(W - 1));

  assign sgn   = ~op[0];
  assign sa    = sgn & rs_data[W-1];
  assign sb    = sgn & rt_data[W-1];
  assign a_mag = sa ? -rs_data : rs_data;
  assign b_mag = sb ? -rt_data : rt_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc holds {rem, quo} for divide and {partial, multiplier} for multiply
  always_comb begin
    sum   = {1'b0, acc[2*W-1:W]} + {1'b0, b_q};
    trial = {1'b0, acc[2*W-1:W-1]} - {2'b0, b_q};
    if (div_q)
      acc_nxt = trial[W+1] ? {acc[2*W-2:0], 1'b0}
                           : {trial[W-1:0], acc[W-2:0], 1'b1};
    else
      acc_nxt = acc[0] ? {sum, acc[W-1:1]}
                       : {1'b0, acc[2*W-1:1]};
  end

  // divide by zero keeps an all-ones quotient regardless of dividend sign
  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = (neg_q && !dz_q) ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
    rem  = sa_q ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      acc   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      sa_q  <= 1'b0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        cnt   <= '0;
        acc   <= {{W{1'b0}}, a_mag};
        b_q   <= b_mag;
        div_q <= op[1];
        sa_q  <= sa;
        neg_q <= sa ^ sb;
        dz_q  <= (rt_data == '0);
      end else begin
        if (mthi) hi <= rs_data;
        if (mtlo) lo <= rs_data;
      end
    end else if (state == RUN) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        if (div_q) begin
          hi <= rem;
          lo <= quo;
        end else begin
          hi <= prod[2*W-1:W];
          lo <= prod[W-1:0];
        end
      end
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit for the MIPS single-cycle datapath, sitting directly downstream of the decode stage: it consumes register-file operands and the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO controls. It produces the HI and LO registers read by MFHI/MFLO. Operations take 32 iterations; the datapath stalls on `busy`.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (design and verification at 32 only)

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  launch operation selected by `op` (sampled only in IDLE)
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU (equals funct[1:0] of 0x18–0x1B)
- rs_data  input  32  multiplicand / dividend
- rt_data  input  32  multiplier / divisor
- mthi  input  1  write `rs_data` into HI
- mtlo  input  1  write `rs_data` into LO
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  operation in progress; datapath stalls MFHI/MFLO/start/MTHI/MTLO
- done  output  1  one-cycle pulse when HI/LO take a new result

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 latches operands and op, then goes to RUN with iteration counter = 0.
  - Signed ops (MULT, DIV) latch operand magnitudes and record result signs.
- RUN:
  - One iteration per cycle; counter 0..31; goes to DONE after counter 31.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
- RUN→DONE edge: sign correction applied, then HI/LO written.
- DONE: `done`=1 for exactly one cycle, then IDLE. A `start` in DONE is ignored.
- Results:
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = dividend. Still takes the full 32 iterations.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Falls naturally out of magnitude arithmetic with sign fix, with no special case.
- MTHI/MTLO:
  - Honored only in IDLE; write at the clock edge.
  - Ignored in RUN and DONE.
  - If `start` and `mthi`/`mtlo` are asserted together in IDLE, `start` wins and the move is dropped.
  - `mthi` and `mtlo` together write both registers with `rs_data`.
- `start` while `busy` is ignored; the in-flight operation is unaffected.
- HI/LO hold their previous values throughout RUN. Old values stay readable, but the datapath must not read them while busy.

## Timing
- Reset (asynchronous, immediate): state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0, internal accumulators = 0.
- `start` sampled at edge k:
  - `busy`=1 from after edge k through the cycle ending at edge k+32.
  - HI/LO updated at edge k+32.
  - `busy`=0 and `done`=1 in cycle k+32..k+33.
  - IDLE from edge k+33.
- Latency: 32 cycles from start edge to result visible; 33 cycles to next accepted `start`.
- `busy` = (state == RUN); `done` = (state == DONE). Both are registered-state decodes, with no combinational path from inputs.
- Reset mid-RUN aborts the operation; HI/LO go to 0, not to a partial result. The first rising edge after reset deasserts is a normal IDLE edge.
- Operand inputs may change freely after the start edge.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF → at edge k+32: hi = 0xFFFFFFFE, lo = 0x00000001; done pulses one cycle; busy high for exactly 32 cycles.
- MULT −3 (0xFFFFFFFD) × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; then MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 7 / 2 → lo = 3, hi = 1; DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 100 / 0 → lo = 0xFFFFFFFF, hi = 0x00000064 after the full 32 cycles.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 in IDLE → registers updated next edge. Start MULTU 2×3; during RUN, assert mthi and start with other operands → both ignored; final hi = 0, lo = 6.
- Start DIVU; assert reset at iteration 10 → hi = lo = 0, busy = done = 0 immediately. Release reset; MULTU 5×5 → lo = 25, hi = 0 with normal 32-cycle latency.
